// File: rtl/fft_addr_sequencer_if.sv
// Handshake and address bundle between a controller and the FFT address sequencer.
// The sequencer connects through the slave modport; the controller drives start/en/sclr.
interface fft_addr_sequencer_if #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned STG_W = 2
);
  logic               sclr;
  logic               start;
  logic               en;
  logic               busy;
  logic [STG_W-1:0]   stage;
  logic [LOG2N-2:0]   bfly;
  logic [LOG2N-1:0]   addr_a;
  logic [LOG2N-1:0]   addr_b;
  logic [LOG2N-2:0]   tw_idx;
  logic               last;
  logic               done;

  modport master (
    output sclr, start, en,
    input  busy, stage, bfly, addr_a, addr_b, tw_idx, last, done
  );

  modport slave (
    input  sclr, start, en,
    output busy, stage, bfly, addr_a, addr_b, tw_idx, last, done
  );
endinterface

// File: rtl/fft_addr_sequencer.sv
// Radix-2 in-place FFT butterfly address generator: walks stage/butterfly counters
// and decodes the two leg addresses plus twiddle index combinationally from them.
module fft_addr_sequencer #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned STG_W = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_addr_sequencer_if.slave bus
);
  localparam int unsigned      BflyW     = LOG2N - 1;
  localparam logic [STG_W-1:0] LastStage = STG_W'(LOG2N - 1);
  localparam logic [BflyW-1:0] BflyMax   = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [BflyW-1:0] bfly_q, bfly_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stage_q <= '0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    if (bus.sclr) begin
      state_d = StIdle;
      stage_d = '0;
      bfly_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StRun;
            stage_d = '0;
            bfly_d  = '0;
          end
        end
        StRun: begin
          if (bus.en) begin
            if (bfly_q != BflyMax) begin
              bfly_d = bfly_q + BflyW'(1);
            end else begin
              bfly_d = '0;
              if (stage_q == LastStage) begin
                state_d = StDone;
                stage_d = '0;
              end else begin
                stage_d = stage_q + STG_W'(1);
              end
            end
          end
        end
        StDone: state_d = StIdle;
        default: begin
          state_d = StIdle;
          stage_d = '0;
          bfly_d  = '0;
        end
      endcase
    end
  end

  // addr_a is k with a zero bit inserted at position s; addr_b sets that bit.
  logic [LOG2N-1:0] k_ext, half, pos, grp_part, addr_a;
  logic [STG_W-1:0] tw_sh;

  always_comb begin
    k_ext    = {1'b0, bfly_q};
    half     = LOG2N'(1) << stage_q;
    pos      = k_ext & (half - LOG2N'(1));
    grp_part = (k_ext >> stage_q) << stage_q;
    addr_a   = (grp_part << 1) | pos;
    tw_sh    = LastStage - stage_q;
  end

  assign bus.addr_a = addr_a;
  assign bus.addr_b = addr_a | half;
  assign bus.tw_idx = BflyW'(pos << tw_sh);
  assign bus.stage  = stage_q;
  assign bus.bfly   = bfly_q;
  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.last   = (state_q == StRun) && (stage_q == LastStage) && (bfly_q == BflyMax);
endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Bench for fft_addr_sequencer: a pass-counter model checked every cycle on a LOG2N=3
// instance under random stimulus, literal sequences, and a full LOG2N=10 pass.
module tb_fft_addr_sequencer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  fft_addr_sequencer_if #(.LOG2N(3), .STG_W(2))  if3 ();
  fft_addr_sequencer_if #(.LOG2N(10), .STG_W(4)) if10 ();

  fft_addr_sequencer #(.LOG2N(3), .STG_W(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  fft_addr_sequencer #(.LOG2N(10), .STG_W(4)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if10.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode for the cnt-th butterfly of a pass (butterflies numbered linearly).
  function automatic void expect_addr(input int l, input int cnt, output int s, output int k,
                                      output int a, output int b, output int t);
    int h, half, pos, grp;
    h    = 1 << (l - 1);
    s    = cnt / h;
    k    = cnt % h;
    half = 1 << s;
    pos  = k % half;
    grp  = k / half;
    a    = grp * 2 * half + pos;
    b    = a + half;
    t    = (pos << (l - 1 - s)) % h;
  endfunction

  // Model for the LOG2N=3 instance: in-pass flag, done flag, accepted butterfly count.
  localparam int Total3 = 12;
  bit m_busy, m_done;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (if3.sclr) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_busy) begin
      if (if3.start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end else if (if3.en) begin
      if (m_cnt == Total3 - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int e_s, e_k, e_a, e_b, e_t;
  always @(negedge clk) begin
    expect_addr(3, m_cnt, e_s, e_k, e_a, e_b, e_t);
    chk("busy",   int'(if3.busy),   int'(m_busy));
    chk("done",   int'(if3.done),   int'(m_done));
    chk("last",   int'(if3.last),   int'(m_busy && m_cnt == Total3 - 1));
    chk("stage",  int'(if3.stage),  e_s);
    chk("bfly",   int'(if3.bfly),   e_k);
    chk("addr_a", int'(if3.addr_a), e_a);
    chk("addr_b", int'(if3.addr_b), e_b);
    chk("tw_idx", int'(if3.tw_idx), e_t);
  end

  int lit_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  initial begin
    int s, k, a, b, t, done_seen;
    rst_n = 1'b0;
    if3.sclr = 1'b0;  if3.start = 1'b0;  if3.en = 1'b0;
    if10.sclr = 1'b0; if10.start = 1'b0; if10.en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(if3.busy), 0);
    chk("rst_a", int'(if3.addr_a), 0);
    chk("rst_b", int'(if3.addr_b), 1);
    chk("rst_t", int'(if3.tw_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full pass with en held high, pinned to literal addresses.
    if3.start = 1'b1; if3.en = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("seq_a", int'(if3.addr_a), lit_a[i]);
      chk("seq_b", int'(if3.addr_b), lit_b[i]);
      chk("seq_t", int'(if3.tw_idx), lit_t[i]);
      chk("seq_stage", int'(if3.stage), i / 4);
      @(negedge clk);
    end
    chk("seq_done", int'(if3.done), 1);
    chk("seq_busy_done", int'(if3.busy), 0);
    if3.en = 1'b0;
    @(negedge clk);
    chk("seq_done_drop", int'(if3.done), 0);

    // Alternating en: every address held two cycles.
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 23) chk("toggle_done", int'(if3.done), 1);
      if3.en = (i % 2 == 0);
      @(negedge clk);
    end
    if3.en = 1'b0;

    // sclr at stage 1 / bfly 2 beats a simultaneous en.
    if3.start = 1'b1; if3.en = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("sclr_pre_stage", int'(if3.stage), 1);
    chk("sclr_pre_bfly", int'(if3.bfly), 2);
    if3.sclr = 1'b1;
    @(negedge clk);
    if3.sclr = 1'b0; if3.en = 1'b0;
    chk("sclr_busy", int'(if3.busy), 0);
    chk("sclr_a", int'(if3.addr_a), 0);
    chk("sclr_b", int'(if3.addr_b), 1);
    @(negedge clk);
    chk("sclr_no_done", int'(if3.done), 0);

    // Asynchronous reset mid-cycle in stage 2, then restart.
    if3.start = 1'b1; if3.en = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(if3.busy), 0);
    chk("arst_stage", int'(if3.stage), 0);
    @(negedge clk);
    rst_n = 1'b1; if3.en = 1'b0;
    @(negedge clk);
    chk("arst_no_done", int'(if3.done), 0);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    chk("restart_busy", int'(if3.busy), 1);
    chk("restart_a", int'(if3.addr_a), 0);
    chk("restart_b", int'(if3.addr_b), 1);
    repeat (2) @(negedge clk);

    // start during RUN and during DONE is ignored.
    if3.sclr = 1'b1;
    @(negedge clk);
    if3.sclr = 1'b0;
    if3.start = 1'b1; if3.en = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (5) @(negedge clk);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    chk("run_start_stage", int'(if3.stage), 1);
    chk("run_start_bfly", int'(if3.bfly), 2);
    repeat (5) @(negedge clk);
    if3.start = 1'b1;
    @(negedge clk);
    chk("done_start_done", int'(if3.done), 1);
    @(negedge clk);
    chk("done_start_busy", int'(if3.busy), 0);
    if3.start = 1'b0; if3.en = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if3.start = ($urandom_range(0, 7) == 0);
      if3.en    = ($urandom_range(0, 2) != 0);
      if3.sclr  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    if3.start = 1'b0; if3.en = 1'b0; if3.sclr = 1'b0;
    repeat (3) @(negedge clk);

    // Full LOG2N=10 pass.
    done_seen = 0;
    if10.start = 1'b1; if10.en = 1'b1;
    @(negedge clk);
    if10.start = 1'b0;
    for (int c = 0; c < 5120; c++) begin
      expect_addr(10, c, s, k, a, b, t);
      chk("n10_busy", int'(if10.busy), 1);
      chk("n10_stage", int'(if10.stage), s);
      chk("n10_bfly", int'(if10.bfly), k);
      chk("n10_a", int'(if10.addr_a), a);
      chk("n10_b", int'(if10.addr_b), b);
      chk("n10_t", int'(if10.tw_idx), t);
      chk("n10_last", int'(if10.last), int'(c == 5119));
      if (c == 5119) begin
        chk("n10_final_a", int'(if10.addr_a), 511);
        chk("n10_final_b", int'(if10.addr_b), 1023);
        chk("n10_final_t", int'(if10.tw_idx), 511);
      end
      if (if10.done) done_seen++;
      @(negedge clk);
    end
    if10.en = 1'b0;
    chk("n10_early_done", done_seen, 0);
    chk("n10_done", int'(if10.done), 1);
    @(negedge clk);
    chk("n10_done_single", int'(if10.done), 0);
    chk("n10_idle", int'(if10.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_addr_sequencer.md
FFT_ADDR_SEQUENCER -- requirements
Module: fft_addr_sequencer

Interface
REQ-001 Parameter LOG2N, default 3, is log2 of FFT size N; legal range 2..10.
REQ-002 Parameter STG_W, default 2, is the stage counter width; it SHALL satisfy 2^STG_W >= LOG2N.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 sclr  input  1  synchronous clear; highest priority after rst_n.
REQ-006 start  input  1  one-cycle request to begin a full N-point pass.
REQ-007 en  input  1  advance one butterfly; honoured only while busy.
REQ-008 busy  output  1  high in RUN state; addresses valid when high.
REQ-009 stage  output  STG_W  current stage index s, 0..LOG2N-1.
REQ-010 bfly  output  LOG2N-1  current butterfly index k within stage, 0..N/2-1.
REQ-011 addr_a  output  LOG2N  upper-leg memory address.
REQ-012 addr_b  output  LOG2N  lower-leg memory address.
REQ-013 tw_idx  output  LOG2N-1  twiddle ROM index.
REQ-014 last  output  1  high when busy, s=LOG2N-1, k=N/2-1.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; the only transitions SHALL be those in REQ-017..REQ-020.
REQ-017 IDLE: start=1 -> RUN with stage=0, bfly=0; otherwise remain in IDLE.
REQ-018 RUN, en=1, k<N/2-1 -> bfly+1, stage unchanged.
REQ-019 RUN, en=1, k=N/2-1, s<LOG2N-1 -> bfly wraps to 0, stage+1.
REQ-020 RUN, en=1, last=1 -> DONE, bfly=0, stage=0; DONE -> IDLE unconditionally next cycle.
REQ-021 RUN with en=0 SHALL hold all counters and outputs (stall).
REQ-022 start SHALL be ignored in RUN and DONE; no restart mid-pass.
REQ-023 en SHALL be ignored in IDLE and DONE; counters stay 0.
REQ-024 sclr=1 in any state -> IDLE, stage=0, bfly=0 at the next edge, overriding start and en in the same cycle.
REQ-025 Address decode SHALL be combinational from the registered counters (zero latency), with half=2^s, pos=k mod half, grp=k div half.
REQ-026 addr_a = grp*2^(s+1) + pos; addr_b = addr_a + half; both LOG2N bits, no overflow for legal s,k.
REQ-027 tw_idx = pos shifted left by (LOG2N-1-s), truncated to LOG2N-1 bits.
REQ-028 done SHALL be 1 only in DONE state, i.e. the cycle after the edge accepting the final en.
REQ-029 A full pass SHALL take exactly LOG2N*N/2 accepted en cycles.
REQ-030 Outside RUN, busy=0 and last=0; addr/tw outputs decode from zeroed counters (addr_a=0, addr_b=1, tw_idx=0).

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, force IDLE, stage=0, bfly=0, busy=0, done=0, last=0.
REQ-032 Release of rst_n SHALL be clock-synchronous; first FSM action is on the first edge with rst_n=1.
REQ-033 rst_n asserted mid-pass SHALL abandon the pass; no done pulse SHALL follow.

Verification
REQ-034 LOG2N=3, start then en held high -> stage0 (a,b)=(0,1),(2,3),(4,5),(6,7), tw=0,0,0,0; stage1 (0,2)t0,(1,3)t2,(4,6)t0,(5,7)t2; stage2 (0,4)t0,(1,5)t1,(2,6)t2,(3,7)t3; done high on cycle 13 after start edge.
REQ-035 LOG2N=3, en toggled 1,0 alternately -> same 12-address sequence, each held 2 cycles; done after 24 RUN cycles.
REQ-036 sclr=1 at stage=1, bfly=2 together with en=1 -> next cycle IDLE, busy=0, addr_a=0, addr_b=1, no done pulse.
REQ-037 rst_n pulsed low mid-cycle at stage=2 -> busy=0, stage=0 before the next clock edge; a later start restarts from (0,1).
REQ-038 start pulsed during RUN at stage=1 -> sequence unaffected; start in the DONE cycle -> ignored, busy stays 0.
REQ-039 LOG2N=10 -> 5120 accepted en, last high only on final butterfly (addr_a=511, addr_b=1023, tw_idx=511), single done pulse.
